trace_buffer_drain: RTL and testbench
=====================================

Name: trace_buffer_drain

Overview:
Sits directly downstream of trace_unit and captures one record per retired instruction-fetch event (address, instruction word), stamping each with a free-running cycle timestamp. It buffers the records in a FIFO and presents them on a valid/ready stream to an off-core consumer (debug host, file-dump bench monitor). The fetch path can never be stalled by tracing. When the buffer is full, records are dropped and counted rather than back-pressured.

Parameters:
ADDR_WIDTH, 32, width of traced fetch address
DATA_WIDTH, 32, width of traced instruction word
DEPTH, 16, FIFO entries; power of two, >= 2
TS_WIDTH, 32, timestamp counter width
DROP_CNT_WIDTH, 16, dropped-record counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  capture enable (level)
flush_i  in  1  synchronous FIFO flush (pulse)
clear_stats_i  in  1  synchronous clear of drop counter and overflow flag
trace_valid_i  in  1  trace_unit record valid (single-cycle strobe, no ready)
trace_addr_i  in  ADDR_WIDTH  fetch address
trace_instr_i  in  DATA_WIDTH  fetched instruction
out_valid_o  out  1  head record valid
out_ready_i  in  1  consumer accepts head record
out_addr_o  out  ADDR_WIDTH  head address
out_instr_o  out  DATA_WIDTH  head instruction
out_ts_o  out  TS_WIDTH  head timestamp
count_o  out  $clog2(DEPTH)+1  occupancy
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
overflow_o  out  1  sticky, at least one record dropped
drop_cnt_o  out  DROP_CNT_WIDTH  dropped-record count, saturating
state_o  out  2  FSM state encoding (debug)

Behaviour:
- Reset (async, rst_ni low): pointers 0, count_o 0, empty_o 1, full_o 0, out_valid_o 0, out data outputs 0, overflow_o 0, drop_cnt_o 0, timestamp 0, state IDLE.
- Timestamp: increments every cycle after reset, wraps modulo 2^TS_WIDTH; record is stamped with the counter value in the cycle trace_valid_i is sampled.
- FSM: IDLE (encoding 0): no capture; enable_i=1 -> CAPTURE. CAPTURE (1): push on trace_valid_i; enable_i=0 -> DRAIN. DRAIN (2): no capture; the consumer empties the FIFO; empty -> IDLE; enable_i=1 -> CAPTURE. The state is a registered flag: the push decision uses the current state, so the transition cycle itself does not capture.
- Push: trace_valid_i && state==CAPTURE. Written at wr_ptr on the rising edge. Visible on outputs the next cycle (first-word-fall-through, 1-cycle latency into an empty FIFO).
- Pop: out_valid_o && out_ready_i. Head advances on the edge. out_valid_o == !empty. Out data is driven combinationally from the head entry and is stable while valid && !ready.
- Full push without pop: record dropped; drop_cnt_o +1, saturating at all-ones; overflow_o set.
- Full push with simultaneous pop: accepted, no drop, count unchanged.
- Empty, push with out_ready_i=1: no bypass; the push lands and is popped at the earliest one cycle later.
- flush_i: count 0, pointers 0, and out_valid_o 0 next cycle. A coincident push is discarded and not counted as a drop. The FSM state is unchanged, except that DRAIN goes to IDLE.
- clear_stats_i: drop_cnt_o 0 and overflow_o 0. A coincident drop still wins: drop_cnt_o becomes 1 and overflow_o 1.
- Pointer width is $clog2(DEPTH) and wraps naturally. Full/empty are derived from count, not from pointer comparison.

Decomposition:
- ryuki_datatypes gains a packed struct trace_record_t {addr, instr, ts} and a trace_buf_state_e enum {TB_IDLE, TB_CAPTURE, TB_DRAIN}.
- Depth and width defaults become defines in ryuki_defines (TRACE_BUFFER_SIZE feeds DEPTH).
- One sub-module is natural: ryuki_sync_fifo, a generic FWFT FIFO parameterised by type/width and depth. It exposes push/pop/count/full/empty. The top level holds the FSM, timestamp and drop accounting.

Test Plan:
1. Reset, enable_i=1, 3 pushes at ts 5,6,7 with out_ready_i=1 -> records appear in order with out_ts_o 5,6,7. Each out_valid_o rises one cycle after its push.
2. out_ready_i=0, 20 pushes into DEPTH=16 -> full_o=1, count_o=16, drop_cnt_o=4, overflow_o=1. Drain yields the first 16 records in order.
3. Full FIFO, push and pop in the same cycle -> count stays 16, drop_cnt_o unchanged, new record is at the tail.
4. enable_i dropped with 5 entries queued -> state DRAIN, subsequent trace_valid_i ignored, 5 records emerge, then state IDLE and empty_o=1.
5. flush_i with 7 entries and a coincident push -> next cycle count_o=0, out_valid_o=0, drop_cnt_o unchanged. Then clear_stats_i -> drop_cnt_o=0, overflow_o=0.
6. rst_ni asserted mid-stream with out_valid_o=1 -> all outputs at reset values immediately, without a clock edge. Timestamp restarts at 0 after release.

Source files
------------

// File: rtl/trace_buffer_drain_pkg.sv
// -----------------------------------------------------------------------------
// trace_buffer_drain_pkg
// Shared definitions for the trace buffer drain block: default widths and
// depth, the FSM state encoding, and the next-state function used by the top.
// -----------------------------------------------------------------------------
package trace_buffer_drain_pkg;

    localparam int TB_ADDR_WIDTH      = 32;
    localparam int TB_DATA_WIDTH      = 32;
    localparam int TRACE_BUFFER_SIZE  = 16;
    localparam int TB_TS_WIDTH        = 32;
    localparam int TB_DROP_CNT_WIDTH  = 16;

    // State encoding is fixed because state_o exposes it for debug.
    typedef logic [1:0] tb_state_t;

    localparam tb_state_t TB_IDLE    = 2'd0;
    localparam tb_state_t TB_CAPTURE = 2'd1;
    localparam tb_state_t TB_DRAIN   = 2'd2;

    // A flush while draining has nothing left to drain, so it returns to IDLE.
    // The unused encoding recovers to IDLE.
    function automatic tb_state_t tb_next_state(input tb_state_t cur,
                                                input logic      enable,
                                                input logic      empty,
                                                input logic      flush);
        tb_state_t nxt;
        nxt = cur;
        case (cur)
            TB_IDLE: begin
                if (enable) nxt = TB_CAPTURE;
            end
            TB_CAPTURE: begin
                if (!enable) nxt = TB_DRAIN;
            end
            TB_DRAIN: begin
                if (flush)       nxt = TB_IDLE;
                else if (enable) nxt = TB_CAPTURE;
                else if (empty)  nxt = TB_IDLE;
            end
            default: nxt = TB_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/trace_buffer_drain_fifo.sv
// -----------------------------------------------------------------------------
// trace_buffer_drain_fifo
// Generic synchronous first-word-fall-through FIFO. The head entry is visible
// on rdata_o whenever the FIFO is non-empty; reads as zero when empty.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write wdata_i (accepted if not full, or full with a pop)
//   pop_i           advance head (ignored when empty)
//   flush_i         drop all contents; overrides push and pop
//   wdata_i         write data
//   rdata_o         head data
//   count_o         occupancy, 0..DEPTH
//   full_o, empty_o derived from occupancy
// -----------------------------------------------------------------------------
module trace_buffer_drain_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic do_push;
    logic do_pop;
    logic wr_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: every signal gets its default at the top of always_comb so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_en    = do_push && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) wide and wrap on their own.
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // values from before the edge, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is never read before it
    // is written because rdata_o is masked while empty, and leaving it
    // unreset lets it map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/trace_buffer_drain.sv
// -----------------------------------------------------------------------------
// trace_buffer_drain
// Captures trace_unit fetch records (address, instruction) with a free-running
// timestamp into a FIFO and streams them out on a valid/ready interface. The
// fetch side is never stalled: a record arriving when the FIFO is full (and
// not being popped that cycle) is dropped and counted.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   enable_i                 capture enable (level)
//   flush_i                  empty the FIFO (pulse)
//   clear_stats_i            clear drop counter and overflow flag (pulse)
//   trace_valid_i/addr/instr incoming record strobe and payload
//   out_valid_o/ready_i      head record handshake
//   out_addr/instr/ts_o      head record payload
//   count_o, full_o, empty_o occupancy
//   overflow_o, drop_cnt_o   sticky drop flag, saturating drop count
//   state_o                  FSM state (debug)
// -----------------------------------------------------------------------------
module trace_buffer_drain
    import trace_buffer_drain_pkg::*;
#(
    parameter int ADDR_WIDTH     = TB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = TB_DATA_WIDTH,
    parameter int DEPTH          = TRACE_BUFFER_SIZE,
    parameter int TS_WIDTH       = TB_TS_WIDTH,
    parameter int DROP_CNT_WIDTH = TB_DROP_CNT_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      flush_i,
    input  logic                      clear_stats_i,
    input  logic                      trace_valid_i,
    input  logic [ADDR_WIDTH-1:0]     trace_addr_i,
    input  logic [DATA_WIDTH-1:0]     trace_instr_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ADDR_WIDTH-1:0]     out_addr_o,
    output logic [DATA_WIDTH-1:0]     out_instr_o,
    output logic [TS_WIDTH-1:0]       out_ts_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      overflow_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic [1:0]                state_o
);

    localparam int RW = ADDR_WIDTH + DATA_WIDTH + TS_WIDTH;

    tb_state_t                 state_q,    state_d;
    logic [TS_WIDTH-1:0]       ts_q,       ts_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      overflow_q, overflow_d;

    logic          push_req;
    logic          pop;
    logic          drop;
    logic [RW-1:0] head_rec;
    logic [RW-1:0] in_rec;

    // Record layout in the FIFO: {addr, instr, ts}.
    assign in_rec = {trace_addr_i, trace_instr_i, ts_q};

    trace_buffer_drain_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_req),
        .pop_i   (out_ready_i),
        .flush_i (flush_i),
        .wdata_i (in_rec),
        .rdata_o (head_rec),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    assign out_valid_o = !empty_o;
    assign {out_addr_o, out_instr_o, out_ts_o} = head_rec;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign state_o     = state_q;

    always_comb begin
        // Capture decision uses the registered state, so the cycle in which
        // enable_i changes does not itself capture.
        push_req = trace_valid_i && (state_q == TB_CAPTURE);
        pop      = out_valid_o && out_ready_i;
        // A flushed push is discarded, not dropped; a pop on a full FIFO
        // frees the slot the push lands in.
        drop     = push_req && full_o && !pop && !flush_i;

        ts_d     = ts_q + TS_WIDTH'(1);
        state_d  = tb_next_state(state_q, enable_i, empty_o, flush_i);

        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clear_stats_i) begin
            // A drop in the clearing cycle survives the clear.
            drop_cnt_d = drop ? DROP_CNT_WIDTH'(1) : '0;
            overflow_d = drop;
        end else if (drop) begin
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= TB_IDLE;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_trace_buffer_drain.sv
// -----------------------------------------------------------------------------
// tb_trace_buffer_drain
// Self-checking bench for trace_buffer_drain (default parameters, DEPTH=16).
// Accepted records are pushed onto a scoreboard queue when driven and compared
// against the head when the DUT pops them. Inputs are driven and outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_trace_buffer_drain;

    localparam int          DEPTH     = 16;
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_CAPTURE = 2'd1;
    localparam logic [1:0]  S_DRAIN   = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ts;
    } rec_t;

    logic        clk_i;
    logic        rst_ni;
    logic        enable_i;
    logic        flush_i;
    logic        clear_stats_i;
    logic        trace_valid_i;
    logic [31:0] trace_addr_i;
    logic [31:0] trace_instr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_addr_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_ts_o;
    logic [4:0]  count_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic [1:0]  state_o;

    trace_buffer_drain dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .flush_i       (flush_i),
        .clear_stats_i (clear_stats_i),
        .trace_valid_i (trace_valid_i),
        .trace_addr_i  (trace_addr_i),
        .trace_instr_i (trace_instr_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_addr_o    (out_addr_o),
        .out_instr_o   (out_instr_o),
        .out_ts_o      (out_ts_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o),
        .state_o       (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference timestamp: cycles since reset release.
    logic [31:0] tb_cycle;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tb_cycle <= '0;
        else         tb_cycle <= tb_cycle + 32'd1;
    end

    rec_t       sb[$];
    logic [1:0] m_state;
    int         tests_run;
    int         tests_failed;
    int         pops_seen;

    task automatic model_reset();
        sb.delete();
        m_state = S_IDLE;
    endtask

    task automatic drive(input logic v, input logic rdy);
        trace_valid_i = v;
        trace_addr_i  = $urandom;
        trace_instr_i = $urandom;
        out_ready_i   = rdy;
    endtask

    // One clock cycle: called on a falling edge with inputs already driven.
    // Checks the head against the scoreboard, advances the reference model,
    // then crosses the rising edge and returns on the next falling edge.
    task automatic tick();
        int   n;
        logic m_pop;
        rec_t exp_rec;
        rec_t got_rec;
        rec_t new_rec;
        n     = sb.size();
        m_pop = (n != 0) && out_ready_i;

        tests_run++;
        if (out_valid_o !== (n != 0)) begin
            tests_failed++;
            $display("FAIL out_valid: got %b expected %b (t=%0t)", out_valid_o, (n != 0), $time);
        end

        if (out_valid_o && out_ready_i) pops_seen++;

        if (m_pop) begin
            exp_rec = sb.pop_front();
            got_rec = {out_addr_o, out_instr_o, out_ts_o};
            tests_run++;
            if (got_rec !== exp_rec) begin
                tests_failed++;
                $display("FAIL pop_record: got addr=%h instr=%h ts=%0d expected addr=%h instr=%h ts=%0d",
                         got_rec.addr, got_rec.instr, got_rec.ts, exp_rec.addr, exp_rec.instr, exp_rec.ts);
            end
        end

        if (flush_i) begin
            sb.delete();
        end else if (trace_valid_i && m_state == S_CAPTURE && (n < DEPTH || m_pop)) begin
            new_rec.addr  = trace_addr_i;
            new_rec.instr = trace_instr_i;
            new_rec.ts    = tb_cycle;
            sb.push_back(new_rec);
        end

        case (m_state)
            S_IDLE:    if (enable_i) m_state = S_CAPTURE;
            S_CAPTURE: if (!enable_i) m_state = S_DRAIN;
            default: begin
                if (flush_i)       m_state = S_IDLE;
                else if (enable_i) m_state = S_CAPTURE;
                else if (n == 0)   m_state = S_IDLE;
            end
        endcase

        @(posedge clk_i);
        @(negedge clk_i);

        tests_run++;
        if (count_o !== 5'(sb.size())) begin
            tests_failed++;
            $display("FAIL count: got %0d expected %0d (t=%0t)", count_o, sb.size(), $time);
        end
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        enable_i      = 1'b0;
        flush_i       = 1'b0;
        clear_stats_i = 1'b0;
        drive(1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk_i);
        tests_run++;
        if ({out_valid_o, count_o, empty_o, full_o, overflow_o, drop_cnt_o, state_o} !==
            {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd0, S_IDLE}) begin
            tests_failed++;
            $display("FAIL reset_status: got valid=%b count=%0d empty=%b full=%b ovf=%b drop=%0d state=%0d expected 0 0 1 0 0 0 0",
                     out_valid_o, count_o, empty_o, full_o, overflow_o, drop_cnt_o, state_o);
        end
        tests_run++;
        if ({out_addr_o, out_instr_o, out_ts_o} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0", {out_addr_o, out_instr_o, out_ts_o});
        end
        rst_ni = 1'b1;
    endtask

    // Pushes at timestamps 5, 6, 7 with the consumer always ready.
    task automatic test_basic();
        logic [31:0] exp_ts;
        enable_i = 1'b1;
        for (int i = 0; i < 20 && tb_cycle < 32'd5; i++) begin
            drive(1'b0, 1'b1);
            tick();
        end
        tests_run++;
        if (state_o !== S_CAPTURE) begin
            tests_failed++;
            $display("FAIL basic_state: got %0d expected %0d", state_o, S_CAPTURE);
        end
        exp_ts = 32'd5;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            tick();
            tests_run++;
            if (out_valid_o !== 1'b1 || out_ts_o !== exp_ts) begin
                tests_failed++;
                $display("FAIL basic_ts: got valid=%b ts=%0d expected valid=1 ts=%0d", out_valid_o, out_ts_o, exp_ts);
            end
            exp_ts = exp_ts + 32'd1;
        end
        drive(1'b0, 1'b1);
        tick();
        tests_run++;
        if (empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_empty: got %b expected 1", empty_o);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        tests_run++;
        if ({full_o, count_o, drop_cnt_o, overflow_o} !== {1'b1, 5'd16, 16'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL overflow_stats: got full=%b count=%0d drop=%0d ovf=%b expected 1 16 4 1",
                     full_o, count_o, drop_cnt_o, overflow_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1);
            tick();
        end
        tests_run++;
        if (empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_drain_empty: got %b expected 1", empty_o);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1);
        tick();
        tests_run++;
        if ({full_o, count_o, drop_cnt_o} !== {1'b1, 5'd16, 16'd4}) begin
            tests_failed++;
            $display("FAIL full_push_pop: got full=%b count=%0d drop=%0d expected 1 16 4",
                     full_o, count_o, drop_cnt_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1);
            tick();
        end
        tests_run++;
        if (empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_push_pop_empty: got %b expected 1", empty_o);
        end
    endtask

    task automatic test_drain();
        int pops_before;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        enable_i = 1'b0;
        drive(1'b0, 1'b0);
        tick();
        tests_run++;
        if (state_o !== S_DRAIN) begin
            tests_failed++;
            $display("FAIL drain_state: got %0d expected %0d", state_o, S_DRAIN);
        end
        pops_before = pops_seen;
        for (int i = 0; i < 20 && state_o != S_IDLE; i++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        tests_run++;
        if (state_o !== S_IDLE || empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_idle: got state=%0d empty=%b expected state=0 empty=1", state_o, empty_o);
        end
        tests_run++;
        if (pops_seen - pops_before != 5) begin
            tests_failed++;
            $display("FAIL drain_pops: got %0d expected 5", pops_seen - pops_before);
        end
    endtask

    task automatic test_flush_clear();
        enable_i = 1'b1;
        drive(1'b0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        flush_i = 1'b1;
        drive(1'b1, 1'b0);
        tick();
        flush_i = 1'b0;
        tests_run++;
        if ({count_o, out_valid_o, drop_cnt_o, state_o} !== {5'd0, 1'b0, 16'd4, S_CAPTURE}) begin
            tests_failed++;
            $display("FAIL flush: got count=%0d valid=%b drop=%0d state=%0d expected 0 0 4 1",
                     count_o, out_valid_o, drop_cnt_o, state_o);
        end
        clear_stats_i = 1'b1;
        drive(1'b0, 1'b0);
        tick();
        clear_stats_i = 1'b0;
        tests_run++;
        if ({drop_cnt_o, overflow_o} !== {16'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL clear_stats: got drop=%0d ovf=%b expected 0 0", drop_cnt_o, overflow_o);
        end
        // Drop coinciding with a clear: the drop wins.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        clear_stats_i = 1'b1;
        drive(1'b1, 1'b0);
        tick();
        clear_stats_i = 1'b0;
        tests_run++;
        if ({drop_cnt_o, overflow_o} !== {16'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL clear_with_drop: got drop=%0d ovf=%b expected 1 1", drop_cnt_o, overflow_o);
        end
        // Flush while draining returns to IDLE.
        enable_i = 1'b0;
        drive(1'b0, 1'b0);
        tick();
        flush_i = 1'b1;
        drive(1'b0, 1'b0);
        tick();
        flush_i = 1'b0;
        tests_run++;
        if (state_o !== S_IDLE || count_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_drain: got state=%0d count=%0d expected 0 0", state_o, count_o);
        end
    endtask

    task automatic test_async_reset();
        enable_i = 1'b1;
        drive(1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        tests_run++;
        if (out_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_valid: got %b expected 1", out_valid_o);
        end
        // Assert reset between clock edges; outputs must clear without an edge.
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({out_valid_o, count_o, empty_o, full_o, overflow_o, drop_cnt_o, state_o} !==
            {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd0, S_IDLE}) begin
            tests_failed++;
            $display("FAIL async_reset_status: got valid=%b count=%0d empty=%b full=%b ovf=%b drop=%0d state=%0d expected 0 0 1 0 0 0 0",
                     out_valid_o, count_o, empty_o, full_o, overflow_o, drop_cnt_o, state_o);
        end
        tests_run++;
        if ({out_addr_o, out_instr_o, out_ts_o} !== 96'd0) begin
            tests_failed++;
            $display("FAIL async_reset_data: got %h expected 0", {out_addr_o, out_instr_o, out_ts_o});
        end
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        // First edge after release has timestamp 0 and moves IDLE->CAPTURE;
        // the push on the next edge is stamped 1.
        drive(1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1);
        tick();
        tests_run++;
        if (out_valid_o !== 1'b1 || out_ts_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL ts_restart: got valid=%b ts=%0d expected valid=1 ts=1", out_valid_o, out_ts_o);
        end
        drive(1'b0, 1'b1);
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pops_seen    = 0;
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_drain();
        test_flush_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
